ifft_frame_loader: RTL and testbench
====================================

Name: ifft_frame_loader

Overview:
- Downstream neighbour of the bit-to-symbol mapper. Takes each 9-bit constellation ROM address the mapper emits, reads the I and Q constellation ROMs (1-cycle sync read) and packs the resulting I/Q pairs into a ping-pong frame buffer of FRAME_LEN symbols.
- Streams full frames to the IFFT over a valid/ready interface with start/end-of-frame markers.
- Zero-pads a partial final frame on flush.

Parameters:
- FRAME_LEN, 64, symbols per IFFT frame; power of two, 8..256
- DW, 16, width of each I and Q sample (two's complement)
- AW, 9, constellation ROM address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sym_valid  in  1  one-cycle strobe; sym_addr valid (mapper done)
- sym_addr  in  AW  constellation ROM address from mapper
- flush  in  1  one-cycle strobe; close current partial frame (mapper done_mapper rising edge)
- rom_addr  out  AW  address to I/Q ROMs, registered
- rom_i  in  DW  I ROM data, valid 1 cycle after rom_addr
- rom_q  in  DW  Q ROM data, valid 1 cycle after rom_addr
- out_valid  out  1  sample valid to IFFT
- out_ready  in  1  IFFT accepts sample
- out_i  out  DW  I sample
- out_q  out  DW  Q sample
- out_sop  out  1  first sample of frame, qualified by out_valid
- out_eop  out  1  last sample of frame, qualified by out_valid
- overflow  out  1  sticky; a symbol was dropped
- frame_cnt  out  16  frames delivered, wraps at 65535->0

Behaviour:
- Reset values: rom_addr=0, out_valid=0, out_sop=0, out_eop=0, out_i=0, out_q=0, overflow=0, frame_cnt=0.
- Internal state on reset: both banks empty, fill bank=0, drain bank=0, all pointers 0. Reset mid-frame discards all buffered data.
- Write pipeline, per accepted symbol:
  - Edge E0: sym_valid sampled; rom_addr<=sym_addr; wr_pend1<=1.
  - Edge E1: wr_pend2<=1.
  - Edge E2: {rom_i, rom_q} written to mem[fill_bank][wr_ptr]; wr_ptr++.
  - Back-to-back sym_valid on every cycle is supported.
- Fill side FSM, states FILL, PAD, WAIT:
  - FILL: when a write makes wr_ptr reach FRAME_LEN, mark fill bank full, toggle fill bank, wr_ptr=0. If the new fill bank is still full, go to WAIT.
  - flush in FILL with wr_ptr>0 or writes in flight: let in-flight writes complete, then go to PAD.
  - flush with wr_ptr==0 and nothing in flight is ignored.
  - PAD: write 0/0 one entry per cycle until the frame is full, then mark full, toggle bank, return to FILL (or go to WAIT).
  - WAIT: both banks full. Return to FILL when the drain side releases a bank.
- Overflow: sym_valid in WAIT or PAD is dropped and sets overflow=1. Only rst clears overflow.
- Simultaneous sym_valid and flush: the symbol is accepted and included in the padded frame before padding starts.
- Drain side FSM, states IDLE, STREAM:
  - IDLE: when the drain bank is full, go to STREAM, rd_ptr=0.
  - STREAM: out_valid=1; out_i/out_q=mem[drain_bank][rd_ptr]; out_sop=(rd_ptr==0); out_eop=(rd_ptr==FRAME_LEN-1).
  - On out_valid&&out_ready, rd_ptr++.
  - When the handshake completes with eop: clear drain bank full, toggle drain bank, frame_cnt++. Go to STREAM again if the next bank is already full (zero bubble), else IDLE.
- Outputs are stable while out_valid && !out_ready; no sample is lost or duplicated.
- Same-cycle bank release and fill-side completion: release takes effect first, so the fill side never stalls into WAIT because of that coincidence.
- Latency: sym_valid of the last symbol of a frame to out_valid of that frame's sop = 4 cycles when the drain side is idle.

Decomposition:
- Shared package (modem_pkg):
  - FRAME_LEN default
  - DW, AW
  - fill/drain state encodings
  - Shared with mapper/IFFT wrappers.
- One natural sub-module: iq_pingpong_ram. Two banks x FRAME_LEN x 2*DW, one write port, one asynchronous read port, bank select inputs.
- FSMs and pointers stay in the top module.

Test Plan (all with FRAME_LEN=8):
- ROM model I=addr, Q=-addr; send 8 sym_valid with addr 0..7, out_ready=1 -> 8 samples I=0..7, Q=0..-7, sop on first, eop on last, frame_cnt=1.
- Send 3 symbols (addr 5,6,7) then flush -> one frame I=5,6,7,0,0,0,0,0, eop on index 7, overflow=0.
- out_ready=0; send 16 symbols -> both banks full; a 17th sym_valid sets overflow=1. Then release out_ready -> 16 samples with no gap between frames, frame_cnt=2.
- out_ready toggled 1,0,0,1 pseudo-randomly during drain -> output sequence identical to the ready=1 case, data held while stalled.
- Assert rst mid-frame after 4 symbols, then send 8 fresh symbols -> exactly one frame containing only the fresh symbols; frame_cnt restarts from 0.
- sym_valid and flush in the same cycle as the 2nd symbol -> frame contains both symbols followed by 6 zeros.

Source files
------------

// File: rtl/modem_pkg.sv
// Shared modem definitions: default frame geometry and the frame loader's FSM encodings.
package modem_pkg;

  localparam int FRAME_LEN_DEF = 64;
  localparam int DW_DEF        = 16;
  localparam int AW_DEF        = 9;

  typedef enum logic [1:0] {
    F_FILL = 2'd0,
    F_PAD  = 2'd1,
    F_WAIT = 2'd2
  } fill_state_e;

  typedef enum logic {
    D_IDLE   = 1'b0,
    D_STREAM = 1'b1
  } drain_state_e;

  // One-hot flag for a ping-pong bank index.
  function automatic logic [1:0] bank_mask(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/iq_pingpong_ram.sv
// Two-bank I/Q frame store: one synchronous write port, one asynchronous read port.
module iq_pingpong_ram #(
  parameter int FRAME_LEN = 64,
  parameter int DW        = 16,
  parameter int PW        = $clog2(FRAME_LEN)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            wr_bank,
  input  logic [PW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic            rd_bank,
  input  logic [PW-1:0]   rd_addr,
  output logic [2*DW-1:0] rd_data
);

  logic [2*DW-1:0] mem [2*FRAME_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/ifft_frame_loader.sv
// Packs constellation ROM lookups into ping-pong IQ frames and streams full frames to the IFFT.
module ifft_frame_loader
  import modem_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sym_valid,
  input  logic [AW-1:0] sym_addr,
  input  logic          flush,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_i,
  input  logic [DW-1:0] rom_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_i,
  output logic [DW-1:0] out_q,
  output logic          out_sop,
  output logic          out_eop,
  output logic          overflow,
  output logic [15:0]   frame_cnt
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam int CW = PW + 2;
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

  fill_state_e  fill_st_q, fill_st_d;
  drain_state_e drn_st_q, drn_st_d;

  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          wr_pend1_q, wr_pend1_d;
  logic          wr_pend2_q, wr_pend2_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          fill_bank_q, fill_bank_d;
  logic          flush_pend_q, flush_pend_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    full_q, full_d;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_bank_q, rd_bank_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic [DW-1:0] out_i_q, out_i_d;
  logic [DW-1:0] out_q_q, out_q_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [CW-1:0]   committed;
  logic            accept;
  logic            wr_en;
  logic            wr_last;
  logic [2*DW-1:0] wr_data;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      full_clr;
  logic [1:0]      full_rel;

  iq_pingpong_ram #(
    .FRAME_LEN (FRAME_LEN),
    .DW        (DW),
    .PW        (PW)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (fill_bank_q),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_bank (rd_bank_d),
    .rd_addr (rd_ptr_d),
    .rd_data (rd_data)
  );

  // Drain side: the RAM is read at the next pointer so the sample lands in the output flops.
  always_comb begin
    drn_st_d    = drn_st_q;
    rd_bank_d   = rd_bank_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    full_clr    = 2'b00;
    if (drn_st_q == D_IDLE) begin
      if (full_q[rd_bank_q]) begin
        drn_st_d    = D_STREAM;
        rd_ptr_d    = '0;
        out_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      if (rd_ptr_q == LAST) begin
        full_clr    = bank_mask(rd_bank_q);
        rd_bank_d   = ~rd_bank_q;
        rd_ptr_d    = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (!full_q[~rd_bank_q]) begin
          drn_st_d    = D_IDLE;
          out_valid_d = 1'b0;
        end
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
    out_i_d   = out_valid_d ? rd_data[2*DW-1:DW] : '0;
    out_q_d   = out_valid_d ? rd_data[DW-1:0] : '0;
    out_sop_d = out_valid_d && (rd_ptr_d == '0);
    out_eop_d = out_valid_d && (rd_ptr_d == LAST);
  end

  // Fill side. Symbols still in the ROM pipeline count against capacity, so a symbol is
  // only taken when it is guaranteed a slot in the current or the next (empty) bank.
  always_comb begin
    committed = CW'(wr_ptr_q) + CW'(wr_pend1_q) + CW'(wr_pend2_q);
    accept    = sym_valid && (fill_st_q == F_FILL) && !flush_pend_q &&
                ((committed < CW'(FRAME_LEN)) || !full_q[~fill_bank_q]);
    wr_en     = wr_pend2_q || (fill_st_q == F_PAD);
    wr_data   = (fill_st_q == F_PAD) ? '0 : {rom_i, rom_q};
    wr_last   = wr_en && (wr_ptr_q == LAST);
    full_rel  = full_q & ~full_clr;
    full_d    = full_rel | (wr_last ? bank_mask(fill_bank_q) : 2'b00);

    rom_addr_d   = accept ? sym_addr : rom_addr_q;
    wr_pend1_d   = accept;
    wr_pend2_d   = wr_pend1_q;
    overflow_d   = overflow_q || (sym_valid && !accept);
    wr_ptr_d     = wr_ptr_q;
    fill_bank_d  = fill_bank_q;
    fill_st_d    = fill_st_q;
    flush_pend_d = flush_pend_q;

    if (wr_en) begin
      if (wr_last) begin
        wr_ptr_d    = '0;
        fill_bank_d = ~fill_bank_q;
        fill_st_d   = full_rel[~fill_bank_q] ? F_WAIT : F_FILL;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
    if ((fill_st_q == F_WAIT) && !full_rel[fill_bank_q]) fill_st_d = F_FILL;

    if (flush && (fill_st_q == F_FILL) && !flush_pend_q &&
        ((wr_ptr_q != '0) || wr_pend1_q || wr_pend2_q || accept))
      flush_pend_d = 1'b1;
    // Padding starts once the ROM pipeline has drained; a frame completed by the
    // in-flight writes leaves nothing to pad.
    if (flush_pend_q && !wr_pend1_q && !wr_pend2_q) begin
      flush_pend_d = 1'b0;
      if (wr_ptr_q != '0) fill_st_d = F_PAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_st_q    <= F_FILL;
      rom_addr_q   <= '0;
      wr_pend1_q   <= 1'b0;
      wr_pend2_q   <= 1'b0;
      wr_ptr_q     <= '0;
      fill_bank_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      full_q       <= 2'b00;
    end else begin
      fill_st_q    <= fill_st_d;
      rom_addr_q   <= rom_addr_d;
      wr_pend1_q   <= wr_pend1_d;
      wr_pend2_q   <= wr_pend2_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_bank_q  <= fill_bank_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
      full_q       <= full_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drn_st_q    <= D_IDLE;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      drn_st_q    <= drn_st_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ifft_frame_loader.sv
// Bench for ifft_frame_loader: frame-level model in queues, per-cycle compare, directed scenarios.
module tb_ifft_frame_loader;

  localparam int FL = 8;
  localparam int DW = 16;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sym_valid = 1'b0;
  logic [AW-1:0] sym_addr = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_i = '0;
  logic [DW-1:0] rom_q = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_i;
  logic [DW-1:0] out_q;
  logic          out_sop;
  logic          out_eop;
  logic          overflow;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [2*DW+1:0] expq[$];
  int              part = 0;
  int              model_fc = 0;
  logic [DW-1:0]   cap_i [FL];
  logic [DW-1:0]   cap_q [FL];
  int              cap_idx = 0;
  logic            held = 1'b0;
  logic [2*DW+2:0] held_vec = '0;

  always #5 clk = ~clk;

  ifft_frame_loader #(.FRAME_LEN(FL), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym_addr  (sym_addr),
    .flush     (flush),
    .rom_addr  (rom_addr),
    .rom_i     (rom_i),
    .rom_q     (rom_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  // Constellation ROM stand-in: I = addr, Q = -addr, one-cycle registered read.
  always @(posedge clk) begin
    rom_i <= DW'(rom_addr);
    rom_q <= -DW'(rom_addr);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_sym(input int a);
    logic [DW-1:0] vi;
    logic [DW-1:0] vq;
    vi = DW'(a);
    vq = -vi;
    expq.push_back({vi, vq, part == 0, part == FL - 1});
    part = (part + 1) % FL;
  endtask

  task automatic model_flush();
    while (part != 0) model_sym(0);
  endtask

  task automatic model_reset();
    expq.delete();
    part = 0;
    model_fc = 0;
  endtask

  task automatic send(input int a, input bit with_flush, input bit expect_accept);
    sym_valid = 1'b1;
    sym_addr  = AW'(a);
    flush     = with_flush;
    if (expect_accept) model_sym(a);
    if (with_flush) model_flush();
    tick();
    sym_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain timeout, %0d samples outstanding want 0", nm, expq.size());
    end
    tick();
  endtask

  // Per-cycle compare against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      chk("frame_cnt", 32'(frame_cnt), 32'(model_fc));
      if (held) chk("stall_hold", 32'({out_valid, out_i, out_q, out_sop, out_eop} != held_vec), 32'd0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_sample", 32'd1, 32'd0);
        end else begin
          logic [2*DW+1:0] e;
          e = expq.pop_front();
          chk("sample_iq", {out_i, out_q}, e[2*DW+1:2]);
          chk("sample_sop_eop", {30'd0, out_sop, out_eop}, {30'd0, e[1:0]});
        end
        if (out_sop) cap_idx = 0;
        if (cap_idx < FL) begin
          cap_i[cap_idx] = out_i;
          cap_q[cap_idx] = out_q;
        end
        cap_idx++;
        if (out_eop) model_fc++;
      end
      held     = out_valid && !out_ready;
      held_vec = {out_valid, out_i, out_q, out_sop, out_eop};
    end
  end

  initial begin
    int lat;
    int nvalid;
    logic [7:0] pat;

    repeat (3) tick();
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_sop", 32'(out_sop), 32'd0);
    chk("rst_eop", 32'(out_eop), 32'd0);
    chk("rst_out_i", 32'(out_i), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Full frame, back-to-back symbols, ready held high; measure sop latency.
    for (int a = 0; a < FL; a++) send(a, 1'b0, 1'b1);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    chk("latency", 32'(lat), 32'd4);
    wait_drain("t1");
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_q7", 32'(cap_q[7]), 32'h0000fff9);

    // Partial frame closed by flush.
    send(5, 1'b0, 1'b1);
    send(6, 1'b0, 1'b1);
    send(7, 1'b0, 1'b1);
    repeat (2) tick();
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    wait_drain("t2");
    chk("t2_i2", 32'(cap_i[2]), 32'd7);
    chk("t2_i3_pad", 32'(cap_i[3]), 32'd0);
    chk("t2_q7_pad", 32'(cap_q[7]), 32'd0);
    chk("t2_overflow", 32'(overflow), 32'd0);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Stalled drain: two frames fill both banks, a 17th symbol overflows.
    out_ready = 1'b0;
    for (int a = 16; a < 32; a++) send(a, 1'b0, 1'b1);
    repeat (6) tick();
    chk("t3_valid_stalled", 32'(out_valid), 32'd1);
    chk("t3_first_i", 32'(out_i), 32'd16);
    chk("t3_overflow_pre", 32'(overflow), 32'd0);
    send(99, 1'b0, 1'b0);
    repeat (3) tick();
    chk("t3_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 2 * FL; k++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("t3_no_gap", 32'(nvalid), 32'(2 * FL));
    wait_drain("t3");
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd4);

    // Ready toggling during drain.
    out_ready = 1'b0;
    for (int a = 50; a < 50 + FL; a++) send(a, 1'b0, 1'b1);
    pat = 8'b1001_0110;
    for (int c = 0; c < 200 && expq.size() != 0; c++) begin
      out_ready = pat[c % 8];
      tick();
    end
    out_ready = 1'b1;
    wait_drain("t4");
    chk("t4_i5", 32'(cap_i[5]), 32'd55);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd5);

    // Reset mid-frame discards buffered symbols.
    for (int a = 200; a < 204; a++) send(a, 1'b0, 1'b1);
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t5_frame_cnt_rst", 32'(frame_cnt), 32'd0);
    chk("t5_overflow_rst", 32'(overflow), 32'd0);
    for (int a = 100; a < 100 + FL; a++) send(a, 1'b0, 1'b1);
    wait_drain("t5");
    chk("t5_i0", 32'(cap_i[0]), 32'd100);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);
    repeat (10) tick();
    chk("t5_no_extra", 32'(out_valid), 32'd0);

    // Flush coincident with the second symbol.
    send(40, 1'b0, 1'b1);
    send(41, 1'b1, 1'b1);
    wait_drain("t6");
    chk("t6_i1", 32'(cap_i[1]), 32'd41);
    chk("t6_q1", 32'(cap_q[1]), 32'h0000ffd7);
    chk("t6_i2_pad", 32'(cap_i[2]), 32'd0);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("t6_overflow", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
